// File: rtl/aes_inv_cntx_pkg.sv
// Shared types and constants for the AES-128 round controllers.
package aes_pkg;

  localparam int AES_NR = 10;
  localparam int RND_W  = 4;

  typedef enum logic [1:0] {
    KEY_IDLE = 2'd0,
    KEY_EXP  = 2'd1,
    DEC      = 2'd2
  } keyst_t;

  typedef struct packed {
    logic [RND_W-1:0] rnd;
    logic             done;
  } ctx_t;

  // One-hot progress: zero at round 0, bit r-1 set at round r.
  function automatic logic [9:0] round_onehot(input logic [RND_W-1:0] r);
    return 10'b10_0000_0000 >> (4'd10 - r);
  endfunction

endpackage

// File: rtl/aes_inv_cntx_if.sv
// Handshake and stage-control bundle between the inverse-cipher controller and its user.
interface aes_inv_cntx_if;
  import aes_pkg::*;

  logic             start;
  logic             key_load;
  logic             key_ready;
  logic             enbKX;
  logic             accept;
  logic [RND_W-1:0] rndNo;
  logic [RND_W-1:0] key_idx;
  logic             enbISR;
  logic             enbISB;
  logic             enbAR;
  logic             enbIMC;
  logic             done;
  logic [9:0]       completed_round;

  modport master (
    output start, key_load,
    input  key_ready, enbKX, accept, rndNo, key_idx,
           enbISR, enbISB, enbAR, enbIMC, done, completed_round
  );

  modport slave (
    input  start, key_load,
    output key_ready, enbKX, accept, rndNo, key_idx,
           enbISR, enbISB, enbAR, enbIMC, done, completed_round
  );

endinterface

// File: rtl/aes_inv_cntx_ctx_ring.sv
// Time-interleaved ring of N round contexts; the tail context is the one the core works on.
module aes_ctx_ring
  import aes_pkg::*;
#(
  parameter int N = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic adv,
  output ctx_t head
);

  ctx_t [N-1:0] ctx_r;
  ctx_t         next_s;

  assign head = ctx_r[N-1];

  // Next-round value for the context re-entering the ring: wraps 10 -> 0 and flags completion.
  always_comb begin
    next_s      = '0;
    next_s.done = (head.rnd == 4'(AES_NR));
    if (head.rnd < 4'(AES_NR)) begin
      next_s.rnd = head.rnd + 4'd1;
    end else begin
      next_s.rnd = 4'd0;
    end
  end

  // Ring shift register; clears on abort, holds when not advancing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctx_r <= '0;
    end else if (clr) begin
      ctx_r <= '0;
    end else if (adv) begin
      ctx_r[0] <= next_s;
      for (int i = 1; i < N; i++) begin
        ctx_r[i] <= ctx_r[i-1];
      end
    end
  end

endmodule

// File: rtl/aes_inv_cntx.sv
// AES-128 inverse-cipher round controller over an N-deep context ring.
// Define AES_INV_KEYEXP_EN to gate decryption behind an on-chip forward key expansion.
module aes_inv_cntx
  import aes_pkg::*;
#(
  parameter int N  = 4,
  parameter int NR = 10
) (
  input  logic           clk,
  input  logic           rst,
  aes_inv_cntx_if.slave  bus
);

  ctx_t             head_s;
  logic [RND_W-1:0] rnd_s;
  logic             dec_s;
  logic             adv_s;
  logic             clr_s;
  logic             enbkx_s;
  logic [9:0]       unused_nr_s;

  assign unused_nr_s = 10'(NR);

`ifdef AES_INV_KEYEXP_EN
  keyst_t           state_r;
  keyst_t           state_nxt_s;
  logic [RND_W-1:0] kcnt_r;
  logic [RND_W-1:0] kcnt_nxt_s;

  // Key-expansion state and cycle counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= KEY_IDLE;
      kcnt_r  <= 4'd0;
    end else begin
      state_r <= state_nxt_s;
      kcnt_r  <= kcnt_nxt_s;
    end
  end

  // Next-state logic; a key_load in any state restarts expansion and flushes the ring.
  always_comb begin
    state_nxt_s = state_r;
    kcnt_nxt_s  = kcnt_r;
    clr_s       = 1'b0;
    if (bus.key_load) begin
      state_nxt_s = KEY_EXP;
      kcnt_nxt_s  = 4'd1;
      clr_s       = 1'b1;
    end else begin
      case (state_r)
        KEY_IDLE: state_nxt_s = KEY_IDLE;
        KEY_EXP: begin
          if (kcnt_r == 4'(AES_NR)) begin
            state_nxt_s = DEC;
            kcnt_nxt_s  = 4'd0;
          end else begin
            kcnt_nxt_s  = kcnt_r + 4'd1;
          end
        end
        DEC:      state_nxt_s = DEC;
        default:  state_nxt_s = KEY_IDLE;
      endcase
    end
  end

  assign dec_s   = (state_r == DEC);
  assign enbkx_s = (state_r == KEY_EXP) && (kcnt_r >= 4'd1) && (kcnt_r <= 4'(AES_NR));
  assign adv_s   = dec_s && bus.start && !bus.key_load;
`else
  logic unused_key_load_s;

  assign unused_key_load_s = bus.key_load;
  assign dec_s   = 1'b1;
  assign enbkx_s = 1'b0;
  assign clr_s   = 1'b0;
  assign adv_s   = bus.start;
`endif

  aes_ctx_ring #(.N(N)) u_ring (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr_s),
    .adv  (adv_s),
    .head (head_s)
  );

  assign rnd_s = head_s.rnd;

  // Stage enables decode from the output context's round and are idle outside decryption.
  assign bus.enbAR  = dec_s;
  assign bus.enbISR = dec_s && (rnd_s >= 4'd1) && (rnd_s <= 4'(AES_NR));
  assign bus.enbISB = dec_s && (rnd_s >= 4'd1) && (rnd_s <= 4'(AES_NR));
  assign bus.enbIMC = dec_s && (rnd_s >= 4'd1) && (rnd_s <= 4'(AES_NR - 1));

  assign bus.key_ready       = dec_s;
  assign bus.enbKX           = enbkx_s;
  assign bus.accept          = (rnd_s == 4'd0);
  assign bus.rndNo           = rnd_s;
  assign bus.key_idx         = 4'(AES_NR) - rnd_s;
  assign bus.done            = head_s.done;
  assign bus.completed_round = round_onehot(rnd_s);

endmodule

// File: tb/tb_aes_inv_cntx.sv
// Randomized and directed bench for aes_inv_cntx against a queue-based context model.
module tb_aes_inv_cntx;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  aes_inv_cntx_if bus ();

  aes_inv_cntx #(.N(4), .NR(10)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference model: queue of contexts, back element is the one at the ring output.
  int q_rnd[$];
  bit q_done[$];
  int m_state;   // 0 idle, 1 expanding, 2 decrypting
  int m_k;

  task automatic model_flush();
    q_rnd.delete();
    q_done.delete();
    for (int i = 0; i < 4; i++) begin
      q_rnd.push_back(0);
      q_done.push_back(1'b0);
    end
  endtask

  task automatic model_reset();
    model_flush();
    m_k = 0;
`ifdef AES_INV_KEYEXP_EN
    m_state = 0;
`else
    m_state = 2;
`endif
  endtask

  task automatic model_advance();
    int r;
    r = q_rnd.pop_back();
    void'(q_done.pop_back());
    q_rnd.push_front((r + 1) % 11);
    q_done.push_front(r == 10);
  endtask

  task automatic model_step(input bit s, input bit kl);
`ifdef AES_INV_KEYEXP_EN
    if (kl) begin
      model_flush();
      m_state = 1;
      m_k = 1;
    end else if (m_state == 1) begin
      if (m_k == 10) begin
        m_state = 2;
        m_k = 0;
      end else begin
        m_k++;
      end
    end else if (m_state == 2 && s) begin
      model_advance();
    end
`else
    if (s) model_advance();
`endif
  endtask

  function automatic int m_rnd();
    return q_rnd[q_rnd.size()-1];
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    int  r;
    bit  dec;
    r   = m_rnd();
    dec = (m_state == 2);
    chk("rndNo",     32'(bus.rndNo),     32'(r));
    chk("done",      32'(bus.done),      32'(q_done[q_done.size()-1]));
    chk("key_idx",   32'(bus.key_idx),   32'(10 - r));
    chk("accept",    32'(bus.accept),    32'(r == 0));
    chk("enbAR",     32'(bus.enbAR),     32'(dec));
    chk("enbISR",    32'(bus.enbISR),    32'(dec && r >= 1));
    chk("enbISB",    32'(bus.enbISB),    32'(dec && r >= 1));
    chk("enbIMC",    32'(bus.enbIMC),    32'(dec && r >= 1 && r <= 9));
    chk("key_ready", 32'(bus.key_ready), 32'(dec));
    chk("enbKX",     32'(bus.enbKX),     32'(m_state == 1 && m_k >= 1 && m_k <= 10));
    chk("completed", 32'(bus.completed_round), (r == 0) ? 32'd0 : (32'd1 << (r - 1)));
  endtask

  task automatic cyc(input bit s, input bit kl);
    bus.start    = s;
    bus.key_load = kl;
    @(posedge clk);
    model_step(s, kl);
    #1;
    check_all();
  endtask

  initial begin
    int  kx;
    bit  found;
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.key_load = 1'b0;
    model_reset();
    #3;
    check_all();
    chk("rst_accept", 32'(bus.accept), 32'd1);
    chk("rst_key_idx", 32'(bus.key_idx), 32'd10);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_all();

`ifdef AES_INV_KEYEXP_EN
    // Idle: start alone does nothing until a key is expanded.
    repeat (3) cyc(1'b1, 1'b0);
    chk("idle_not_ready", 32'(bus.key_ready), 32'd0);
    cyc(1'b1, 1'b1);
    kx = (bus.enbKX === 1'b1) ? 1 : 0;
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, 1'b0);
      if (bus.enbKX === 1'b1) kx++;
    end
    chk("kx_count", 32'(kx), 32'd10);
    chk("kx_ready", 32'(bus.key_ready), 32'd1);
    chk("kx_rnd0", 32'(bus.rndNo), 32'd0);
`endif

    // Continuous advance through a full wrap of all four contexts.
    for (int k = 1; k <= 48; k++) begin
      cyc(1'b1, 1'b0);
      if (k == 3)  chk("still_r0_k3", 32'(bus.rndNo), 32'd0);
      if (k == 4)  chk("r1_k4", 32'(bus.rndNo), 32'd1);
      if (k == 40) chk("r10_k40", 32'(bus.rndNo), 32'd10);
      if (k == 40) chk("imc_r10", 32'(bus.enbIMC), 32'd0);
      if (k == 44) chk("done_k44", 32'(bus.done), 32'd1);
      if (k == 47) chk("r0_k47", 32'(bus.rndNo), 32'd0);
    end

    // Start toggling: ring holds on start=0 cycles.
    for (int k = 0; k < 8; k++) cyc(k % 2 == 0, 1'b0);

    // Random start with occasional key_load.
    repeat (120) cyc(1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0));

    // key_load at round 6 with start high.
    found = 1'b0;
    for (int k = 0; k < 200 && !found; k++) begin
      if (m_state == 2 && m_rnd() == 6) found = 1'b1;
      else cyc(1'b1, 1'b0);
    end
    chk("reach_r6", 32'(found), 32'd1);
    cyc(1'b1, 1'b1);
`ifdef AES_INV_KEYEXP_EN
    chk("abort_rnd", 32'(bus.rndNo), 32'd0);
    chk("abort_ready", 32'(bus.key_ready), 32'd0);
    chk("abort_isb", 32'(bus.enbISB), 32'd0);
    kx = (bus.enbKX === 1'b1) ? 1 : 0;
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, 1'b0);
      if (bus.enbKX === 1'b1) kx++;
    end
    chk("abort_kx_count", 32'(kx), 32'd10);
`else
    chk("kl_ignored_rnd", 32'(bus.rndNo), 32'd6);
`endif

    // Asynchronous reset mid-cycle at round 9.
    found = 1'b0;
    for (int k = 0; k < 200 && !found; k++) begin
      if (m_state == 2 && m_rnd() == 9) found = 1'b1;
      else cyc(1'b1, 1'b0);
    end
    chk("reach_r9", 32'(found), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    chk("arst_rnd", 32'(bus.rndNo), 32'd0);
    chk("arst_done", 32'(bus.done), 32'd0);
    check_all();
    @(negedge clk);
    rst = 1'b0;
    repeat (6) cyc(1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/aes_inv_cntx.md
Name: aes_inv_cntx

Overview:
- Controller for the AES-128 inverse-cipher (decryption) core. It is the decrypt-side counterpart of the encryption round controller.
- Sequences round numbers 0..10 through a time-interleaved ring of N contexts, so the core can hold N independent blocks in flight.
- Drives the inverse-stage enables and the round-key index.
- Gates decryption behind a forward key-expansion phase, because decryption consumes the last round key first.

Parameters:
- N, 4, interleave depth: number of contexts in flight in the core; N >= 1.
- NR, 10, number of AES rounds; fixed at 10 for AES-128; sets counter terminal values.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  advance enable; the context ring shifts only on cycles where start=1 and key_ready=1.
- key_load  in  1  one-cycle pulse requesting expansion of a newly presented cipher key.
- key_ready  out  1  high once expansion has completed; decryption may run.
- enbKX  out  1  core steps its forward key expansion this cycle.
- accept  out  1  core latches new ciphertext into the current context (rndNo==0).
- rndNo  out  4  round number of the context currently at the ring output.
- key_idx  out  4  round-key index for AddRoundKey; equals NR-rndNo.
- enbISR  out  1  InvShiftRows enable.
- enbISB  out  1  InvSubBytes enable.
- enbAR  out  1  AddRoundKey enable.
- enbIMC  out  1  InvMixColumns enable.
- done  out  1  plaintext of the current context is valid at the core output.
- completed_round  out  10  one-hot progress for the bench.

Behaviour:
- Reset (rst=1, async): all contexts rnd=0 and done=0; FSM=KEY_IDLE; kcnt=0.
  - Resulting outputs: key_ready=0, enbKX=0, accept=1, rndNo=0, key_idx=10, done=0, completed_round=0.
- FSM states: KEY_IDLE, KEY_EXP, DEC.
  - KEY_IDLE: on key_load, set kcnt<=1 and go to KEY_EXP.
  - KEY_EXP: enbKX=(kcnt in 1..10). kcnt increments each cycle regardless of start. When kcnt==10, next state is DEC with kcnt<=0. Expansion takes exactly 10 cycles.
  - DEC: key_ready=1.
- key_load in KEY_EXP or DEC: abort immediately.
  - Next cycle: all contexts rnd=0 and done=0, kcnt=1, state KEY_EXP.
  - key_load has priority over start in the same cycle.
- Context ring, updated only when advancing (state DEC and start=1):
  - ctx[0].rnd <= (rndNo<10) ? rndNo+1 : 0.
  - ctx[0].done <= (rndNo==10).
  - ctx[i] <= ctx[i-1] for i=1..N-1.
  - rndNo=ctx[N-1].rnd; done=ctx[N-1].done.
- When not advancing, all contexts hold.
- Each context returns to 0 after round 10: wrap 10->0, no 11..15 states ever reached.
- Stage enables are combinational from rndNo and are forced 0 when state!=DEC:
  - enbAR = 1 for all rounds 0..10.
  - enbISR = enbISB = rndNo in 1..10.
  - enbIMC = rndNo in 1..9.
- Decrypt round order the core realises:
  - round 0: AddRoundKey with K10.
  - rounds 1..9: InvShiftRows, InvSubBytes, AddRoundKey(K(10-r)), InvMixColumns.
  - round 10: InvShiftRows, InvSubBytes, AddRoundKey(K0).
- key_idx = 4'd10 - rndNo; always in range 0..10.
- completed_round = 10'b1000000000 >> (10-rndNo): 0 at round 0, bit r-1 set at round r.
- Per-context latency: 11 advancing cycles from accept to rndNo=10; done appears at that context's next turn, i.e. rndNo=0 and done=1 simultaneously.
- accept is not gated by state; the core ignores it unless key_ready=1.

Optional Feature:
- Macro: AES_INV_KEYEXP_EN.
- Defined: KEY_EXP phase exists as above.
- Undefined: no FSM, and the round keys are supplied precomputed.
  - key_ready is tied to 1, enbKX is tied to 0, and key_load is ignored.
  - The ring advances whenever start=1.

Decomposition:
- Package aes_pkg holds:
  - constants AES_NR=10, RND_W=4.
  - enum keyst_t {KEY_IDLE, KEY_EXP, DEC}.
  - a context struct {rnd[3:0], done}.
- Sub-module aes_ctx_ring(N): the parametric shift ring with next-round wrap logic, shared with the encrypt controller.
- FSM, kcnt and enable decode stay in the top module.

Test Plan:
- Reset then key_load pulse, start=1 held:
  - enbKX high for exactly 10 cycles; key_ready rises on the 11th cycle.
  - rndNo stays 0 throughout.
- N=4, after key_ready with start=1 continuous:
  - rndNo at the output is 0 for 4 cycles, then 1 x4, ..., then 10 x4, then 0 with done=1 for 4 cycles.
  - key_idx mirrors as 10..0.
  - enbIMC=0 during rounds 0 and 10.
- start toggled 1,0,1,0 in DEC: ring advances only on start=1 cycles; all outputs hold while start=0.
- key_load asserted when rndNo=6, with start=1 in the same cycle:
  - Next cycle: rndNo=0, done=0, key_ready=0, enbISB=0.
  - Ten cycles of enbKX follow.
- Async rst asserted mid-cycle in DEC at rndNo=9:
  - Outputs go to reset values immediately without waiting for a clock edge: rndNo=0, done=0, key_ready=0.
- Build without AES_INV_KEYEXP_EN:
  - key_ready=1 out of reset; start=1 sequences rounds immediately.
  - key_load pulse has no effect.
